bram_sdp_rdw: RTL and testbench
===============================

Name: bram_sdp_rdw

Overview:
Parametrised simple dual-port block RAM with a write-only port A and a read-only port B.
- Memory is LANES words wide per address, with per-lane write enables.
- Read latency is selectable (1 or 2 cycles); port B flags returning data with a valid pulse.
- Same-address read-during-write behaviour is defined, not device-dependent.
- An optional post-reset zero-clear sweep lets CNN feature-map and accumulator buffers start from known contents.

Parameters:
DW, 16, data width of one lane word (signed)
DEPTH, 1024, number of addresses
AW, (DEPTH<=1)?1:$clog2(DEPTH), address width
LANES, 1, parallel words per address (1..8)
RD_LAT, 1, read latency in cycles; legal values 1 or 2 (elaboration error otherwise)
RDW_MODE, RDW_OLD, same-cycle same-address collision policy: RDW_OLD or RDW_NEW
INIT_ZERO, 1, 1 = run a zero-clear sweep after reset; 0 = no sweep

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
a_en  in  1  port A enable
a_we  in  1  port A write enable
a_addr  in  AW  write address
a_lane_we  in  LANES  per-lane write enable
a_din  in  LANES*DW  write data, signed; lane i = bits [i*DW +: DW]
b_en  in  1  read request
b_addr  in  AW  read address
b_dout  out  LANES*DW  read data, signed, same lane packing
b_valid  out  1  one-cycle pulse: b_dout holds data for a request made RD_LAT cycles earlier
init_busy  out  1  high while the clear sweep runs

Behaviour:
- Reset values: b_dout=0, b_valid=0, init_busy=INIT_ZERO, clear counter=0. Memory array is not reset.
- Init FSM states: CLEAR, READY.
  - Reset enters CLEAR if INIT_ZERO=1, else READY.
  - CLEAR: write all-zero to every lane at address = counter; counter increments each cycle.
  - At counter==DEPTH-1 the write completes and the FSM moves to READY next cycle. init_busy falls on the same edge.
  - The sweep lasts exactly DEPTH cycles after reset release.
  - Reset asserted mid-sweep: asynchronous return to the reset state; the sweep restarts from address 0.
- In CLEAR, a_en/a_we and b_en are ignored: no user writes, no b_valid.
- Write: in READY, with a_en && a_we, lane i is written from a_din lane i at a_addr on the rising edge iff a_lane_we[i]. Unenabled lanes keep their contents.
- Read:
  - In READY, b_en samples b_addr.
  - RD_LAT=1: array output registered once; b_valid pulses in cycle t+1.
  - RD_LAT=2: an extra output register; b_valid pulses in cycle t+2.
  - Back-to-back reads give one result per cycle, in order.
  - b_dout holds its last value when no valid result is returned.
- Collision, defined as same cycle, a_en && a_we, b_en, and a_addr==b_addr:
  - RDW_OLD: result is the pre-write contents.
  - RDW_NEW: written lanes return the new a_din lane; lanes without a_lane_we return old contents. Implemented with a registered bypass (address match, lane mask, data) merged at the first output stage.
- A write landing between a read's issue and its RD_LAT=2 output stage is not forwarded; the result reflects the array at the issue cycle.
- Address out of range (>=DEPTH, non-power-of-2 DEPTH): write dropped; read returns undefined data but b_valid still pulses.

Decomposition:
- Package bram_pkg holds:
  - rdw_mode_e enum {RDW_OLD, RDW_NEW}
  - init_state_e enum {INIT_CLEAR, INIT_READY}
  - the lane-slice helper function for [i*DW +: DW] packing
- Sub-module bram_init_seq holds the clear FSM and counter. It outputs init_busy, clear_we, and clear_addr, which are muxed onto port A.
- The array, per-lane write, bypass and output pipeline stay in the top module.

Test Plan:
- Init: DEPTH=16, INIT_ZERO=1; release rst_n -> init_busy high exactly 16 cycles; then read all 16 addresses -> each b_dout=0, b_valid exactly RD_LAT cycles after each b_en.
- Lane mask: LANES=4, DW=16; write addr 5 all lanes = {0x0004,0x0003,0x0002,0x0001}, then write addr 5 with a_lane_we=4'b0101 and data {0xAAAA,0xBBBB,0xCCCC,0xDDDD} -> read addr 5 gives {0x0004,0xBBBB,0x0002,0xDDDD}.
- Collision: addr 7 holds 0x1234; same cycle write 0x5678 and read addr 7 -> RDW_OLD returns 0x1234, RDW_NEW returns 0x5678; a following read returns 0x5678 in both modes.
- Pipeline: RD_LAT=2; reads of addr 0..9 on 10 consecutive cycles (addr k preloaded with -k) -> b_valid high 10 consecutive cycles starting 2 cycles after the first b_en, data 0,-1,...,-9 in order.
- Reset mid-sweep: DEPTH=16; assert rst_n low at sweep cycle 6, release -> init_busy high a further full 16 cycles; writes and reads attempted during the sweep produce no b_valid and do not alter memory.
- INIT_ZERO=0: init_busy stays 0 from reset; write at the first cycle after release, read back -> the written value.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared types and helpers for the simple dual-port block RAM.
package bram_pkg;

  typedef enum logic {RDW_OLD, RDW_NEW} rdw_mode_e;

  typedef enum logic {INIT_CLEAR, INIT_READY} init_state_e;

  // Low bit of lane `lane` in a packed vector of dw-wide lanes.
  function automatic int unsigned lane_lo(int unsigned lane, int unsigned dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/bram_init_seq.sv
// Post-reset zero-clear sweep: walks every address once, then parks in READY.
module bram_init_seq
  import bram_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned AW        = 10,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          init_busy,
  output logic          clear_we,
  output logic [AW-1:0] clear_addr
);

  localparam init_state_e   RstState = INIT_ZERO ? INIT_CLEAR : INIT_READY;
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  init_state_e   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LastAddr) begin
        state_d = INIT_READY;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RstState;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_busy  = (state_q == INIT_CLEAR);
  assign clear_we   = init_busy;
  assign clear_addr = cnt_q;

endmodule

// File: rtl/bram_sdp_rdw.sv
// Simple dual-port RAM: lane-masked write port A, pipelined read port B with a
// defined same-address read-during-write policy and optional zero-clear sweep.
module bram_sdp_rdw
  import bram_pkg::*;
#(
  parameter int unsigned DW        = 16,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned AW        = (DEPTH <= 1) ? 1 : $clog2(DEPTH),
  parameter int unsigned LANES     = 1,
  parameter int unsigned RD_LAT    = 1,
  parameter rdw_mode_e   RDW_MODE  = RDW_OLD,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_en,
  input  logic                a_we,
  input  logic [AW-1:0]       a_addr,
  input  logic [LANES-1:0]    a_lane_we,
  input  logic [LANES*DW-1:0] a_din,
  input  logic                b_en,
  input  logic [AW-1:0]       b_addr,
  output logic [LANES*DW-1:0] b_dout,
  output logic                b_valid,
  output logic                init_busy
);

  localparam int unsigned W = LANES * DW;

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("bram_sdp_rdw: RD_LAT must be 1 or 2");
  end

  logic          clear_we;
  logic [AW-1:0] clear_addr;

  bram_init_seq #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .INIT_ZERO (INIT_ZERO)
  ) u_init (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_busy  (init_busy),
    .clear_we   (clear_we),
    .clear_addr (clear_addr)
  );

  logic a_addr_ok;
  if (DEPTH == 2 ** AW) begin : g_pow2
    assign a_addr_ok = 1'b1;
  end else begin : g_npow2
    assign a_addr_ok = (32'(a_addr) < DEPTH);
  end

  logic             user_we, wr_en, rd_fire;
  logic [AW-1:0]    wr_addr;
  logic [LANES-1:0] wr_mask;
  logic [W-1:0]     wr_data;

  assign user_we = a_en && a_we && !init_busy && a_addr_ok;
  assign rd_fire = b_en && !init_busy;
  // The clear sweep owns port A while busy.
  assign wr_en   = clear_we || user_we;
  assign wr_addr = init_busy ? clear_addr : a_addr;
  assign wr_mask = init_busy ? '1 : a_lane_we;
  assign wr_data = init_busy ? '0 : a_din;

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wr_mask[i]) begin
          mem_q[wr_addr][lane_lo(i, DW) +: DW] <= wr_data[lane_lo(i, DW) +: DW];
        end
      end
    end
  end

  logic [W-1:0]     rd_raw_q, byp_data_q, s1_data;
  logic [LANES-1:0] byp_mask_q;
  logic             byp_hit_q, v1_q;

  // Stage 1 only advances on a read, so its contents hold between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_raw_q   <= '0;
      byp_hit_q  <= 1'b0;
      byp_mask_q <= '0;
      byp_data_q <= '0;
      v1_q       <= 1'b0;
    end else begin
      v1_q <= rd_fire;
      if (rd_fire) begin
        rd_raw_q   <= mem_q[b_addr];
        byp_hit_q  <= (RDW_MODE == RDW_NEW) && user_we && (a_addr == b_addr);
        byp_mask_q <= a_lane_we;
        byp_data_q <= a_din;
      end
    end
  end

  always_comb begin
    s1_data = rd_raw_q;
    if (byp_hit_q) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (byp_mask_q[i]) begin
          s1_data[lane_lo(i, DW) +: DW] = byp_data_q[lane_lo(i, DW) +: DW];
        end
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [W-1:0] dout2_q;
    logic         v2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout2_q <= '0;
        v2_q    <= 1'b0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) begin
          dout2_q <= s1_data;
        end
      end
    end

    assign b_dout  = dout2_q;
    assign b_valid = v2_q;
  end else begin : g_lat1
    assign b_dout  = s1_data;
    assign b_valid = v1_q;
  end

endmodule

// File: tb/tb_bram_sdp_rdw.sv
// Bench for bram_sdp_rdw: two instances (RD_LAT=1/RDW_OLD/INIT_ZERO=1 and
// RD_LAT=2/RDW_NEW/INIT_ZERO=0) share stimulus and are checked against a model.
module tb_bram_sdp_rdw;
  import bram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_en, a_we, b_en;
  logic [3:0]  a_addr, b_addr, a_lane_we;
  logic [63:0] a_din;
  logic [63:0] dout0, dout1;
  logic        v0, v1, busy0, busy1;

  always #5 clk = ~clk;

  bram_sdp_rdw #(
    .DW (16), .DEPTH (16), .LANES (4), .RD_LAT (1), .RDW_MODE (RDW_OLD), .INIT_ZERO (1'b1)
  ) u_dut_a (
    .clk (clk), .rst_n (rst_n), .a_en (a_en), .a_we (a_we), .a_addr (a_addr),
    .a_lane_we (a_lane_we), .a_din (a_din), .b_en (b_en), .b_addr (b_addr),
    .b_dout (dout0), .b_valid (v0), .init_busy (busy0)
  );

  bram_sdp_rdw #(
    .DW (16), .DEPTH (16), .LANES (4), .RD_LAT (2), .RDW_MODE (RDW_NEW), .INIT_ZERO (1'b0)
  ) u_dut_b (
    .clk (clk), .rst_n (rst_n), .a_en (a_en), .a_we (a_we), .a_addr (a_addr),
    .a_lane_we (a_lane_we), .a_din (a_din), .b_en (b_en), .b_addr (b_addr),
    .b_dout (dout1), .b_valid (v1), .init_busy (busy1)
  );

  int nchk = 0;
  int errs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] mem_m   [2][16];
  logic [3:0]  kn_m    [2][16];
  bit          busy_m  [2];
  int          cnt_m   [2];
  bit          sched_v [2][256];
  logic [63:0] sched_d [2][256];
  bit          sched_k [2][256];
  logic [63:0] last_d  [2];
  bit          last_k  [2];
  int          cyc = 0;
  bit          chk_en = 0;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      busy_m[d] = (d == 0);
      cnt_m[d]  = 0;
      last_d[d] = '0;
      last_k[d] = 1'b1;
      for (int s = 0; s < 256; s++) sched_v[d][s] = 1'b0;
    end
  endtask

  task automatic model_step(input int d);
    logic [63:0] res;
    logic [3:0]  k;
    int          lat, slot;
    lat = (d == 0) ? 1 : 2;
    if (!busy_m[d] && b_en) begin
      res = mem_m[d][b_addr];
      k   = kn_m[d][b_addr];
      if (d == 1 && a_en && a_we && a_addr == b_addr) begin
        for (int l = 0; l < 4; l++) begin
          if (a_lane_we[l]) begin
            res[l*16 +: 16] = a_din[l*16 +: 16];
            k[l] = 1'b1;
          end
        end
      end
      slot = (cyc + lat - 1) % 256;
      sched_v[d][slot] = 1'b1;
      sched_d[d][slot] = res;
      sched_k[d][slot] = &k;
    end
    if (busy_m[d]) begin
      mem_m[d][cnt_m[d]] = '0;
      kn_m[d][cnt_m[d]]  = 4'hf;
      cnt_m[d]++;
      if (cnt_m[d] == 16) busy_m[d] = 1'b0;
    end else if (a_en && a_we) begin
      for (int l = 0; l < 4; l++) begin
        if (a_lane_we[l]) begin
          mem_m[d][a_addr][l*16 +: 16] = a_din[l*16 +: 16];
          kn_m[d][a_addr][l] = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      cyc++;
      model_step(0);
      model_step(1);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int s;
        bit ev;
        s  = cyc % 256;
        ev = sched_v[d][s];
        if (ev) begin
          last_d[d] = sched_d[d][s];
          last_k[d] = sched_k[d][s];
          sched_v[d][s] = 1'b0;
        end
        check(d == 0 ? "cmp_valid_a" : "cmp_valid_b", 64'(d == 0 ? v0 : v1), 64'(ev));
        check(d == 0 ? "cmp_busy_a" : "cmp_busy_b", 64'(d == 0 ? busy0 : busy1),
              64'(busy_m[d]));
        if (last_k[d]) begin
          check(d == 0 ? "cmp_dout_a" : "cmp_dout_b", d == 0 ? dout0 : dout1, last_d[d]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_en = 1'b0; a_we = 1'b0; a_addr = '0; a_lane_we = '0; a_din = '0;
    b_en = 1'b0; b_addr = '0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [3:0] mask, input logic [63:0] data);
    idle();
    a_en = 1'b1; a_we = 1'b1; a_addr = addr; a_lane_we = mask; a_din = data;
    step();
    idle();
  endtask

  task automatic rd(input logic [3:0] addr);
    idle();
    b_en = 1'b1; b_addr = addr;
    step();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    logic [15:0] w;
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 16; a++) begin
        mem_m[d][a] = '0;
        kn_m[d][a]  = 4'h0;
      end
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (3) step();

    check("rst_dout_a", dout0, 64'h0);
    check("rst_valid_a", 64'(v0), 64'h0);
    check("rst_busy_a", 64'(busy0), 64'h1);
    check("rst_dout_b", dout1, 64'h0);
    check("rst_busy_b", 64'(busy1), 64'h0);
    chk_en = 1'b1;

    // INIT_ZERO=0 instance accepts a write on the first cycle after release.
    rst_n = 1'b1;
    wr(4'd3, 4'hf, 64'h0004_0003_0002_cafe);
    rd(4'd3);
    check("b_lat2_not_yet", 64'(v1), 64'h0);
    step();
    check("b_first_write_valid", 64'(v1), 64'h1);
    check("b_first_write_data", dout1, 64'h0004_0003_0002_cafe);
    check("a_busy_mid", 64'(busy0), 64'h1);
    wr(4'd9, 4'hf, 64'h1111_1111_1111_1111);
    rd(4'd9);
    step();

    // Reset mid-sweep: the clear restarts from address 0.
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    n = 0;
    while (busy0 && n < 40) begin
      a_en = 1'b1; a_we = 1'b1; a_addr = 4'(n); a_lane_we = 4'hf;
      a_din = {4{16'(16'h0100 + n)}};
      b_en = 1'b1; b_addr = 4'(n + 3);
      step();
      n++;
    end
    idle();
    check("sweep_cycles", 64'(n), 64'd16);
    step();

    // Cleared array reads back zero, one cycle after each request.
    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      check("clear_valid_a", 64'(v0), 64'h1);
      check("clear_data_a", dout0, 64'h0);
    end
    step();
    step();

    // Lane mask.
    wr(4'd5, 4'hf, 64'h0004_0003_0002_0001);
    wr(4'd5, 4'b0101, 64'haaaa_bbbb_cccc_dddd);
    rd(4'd5);
    step();
    check("lane_mask_a", dout0, 64'h0004_bbbb_0002_dddd);
    check("lane_mask_b", dout1, 64'h0004_bbbb_0002_dddd);

    // Full-word collision.
    wr(4'd7, 4'hf, 64'h0000_0000_0000_1234);
    a_en = 1'b1; a_we = 1'b1; a_addr = 4'd7; a_lane_we = 4'hf; a_din = 64'h0000_0000_0000_5678;
    b_en = 1'b1; b_addr = 4'd7;
    step();
    idle();
    check("coll_old_a", dout0, 64'h0000_0000_0000_1234);
    step();
    check("coll_new_b", dout1, 64'h0000_0000_0000_5678);
    rd(4'd7);
    step();
    check("after_coll_a", dout0, 64'h0000_0000_0000_5678);
    check("after_coll_b", dout1, 64'h0000_0000_0000_5678);

    // Partial-lane collision: only written lanes are forwarded.
    wr(4'd8, 4'hf, 64'h1111_2222_3333_4444);
    a_en = 1'b1; a_we = 1'b1; a_addr = 4'd8; a_lane_we = 4'b0011; a_din = 64'heeee_eeee_eeee_eeee;
    b_en = 1'b1; b_addr = 4'd8;
    step();
    idle();
    check("pcoll_old_a", dout0, 64'h1111_2222_3333_4444);
    step();
    check("pcoll_new_b", dout1, 64'h1111_2222_eeee_eeee);

    // Pipeline: back-to-back reads of addr k preloaded with -k.
    for (int k = 0; k < 10; k++) begin
      w = 16'(0) - 16'(k);
      wr(4'(k), 4'hf, {4{w}});
    end
    for (int i = 0; i < 12; i++) begin
      b_en = (i < 10); b_addr = 4'(i);
      step();
      check("pipe_valid_a", 64'(v0), 64'(i < 10));
      if (i < 10) begin
        w = 16'(0) - 16'(i);
        check("pipe_data_a", dout0, {4{w}});
      end
      check("pipe_valid_b", 64'(v1), 64'(i >= 1 && i <= 10));
      if (i >= 1 && i <= 10) begin
        w = 16'(0) - 16'(i - 1);
        check("pipe_data_b", dout1, {4{w}});
      end
    end
    idle();
    repeat (3) step();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, errs);
    $finish;
  end

endmodule
